// File: rtl/match_seq_pkg.sv
// Shared types for the match_seq block: controller state encoding and default width.
package match_seq_pkg;

  localparam int DEFAULT_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/match_seq_eq_cmp.sv
// Active-low equality comparator: match_n low when a == b. Purely combinational.
module eq_cmp
  import match_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             match_n_o
);

  assign match_n_o = ~(&(~(a_i ^ b_i)));

endmodule

// File: rtl/match_seq.sv
// Event counter against a loadable limit, with one-shot (HOLD until ack) or auto-reload runs.
// count/limit/done are registered; match_n is a combinational compare of the two registers.
module match_seq
  import match_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [WIDTH-1:0] limit_in,
  input  logic             start,
  input  logic             inc,
  input  logic             auto,
  input  logic             ack,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] limit,
  output logic             busy,
  output logic             match_n,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             done_q, done_d;
  logic             match_n_w;

  eq_cmp #(.WIDTH(WIDTH)) u_eq_cmp (
    .a_i       (count_q),
    .b_i       (limit_q),
    .match_n_o (match_n_w)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      limit_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        count_d = '0;
        done_d  = 1'b0;
        if (ld) limit_d = limit_in;
        if (start) state_d = RUN;
      end
      RUN: begin
        done_d = 1'b0;
        // Terminal event is an inc while count already equals limit.
        if (inc) begin
          if (match_n_w) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
          end else if (auto) begin
            count_d = '0;
            done_d  = 1'b1;
          end else begin
            state_d = HOLD;
            done_d  = 1'b1;
          end
        end
      end
      HOLD: begin
        done_d = 1'b1;
        if (ld) limit_d = limit_in;
        if (ack) begin
          count_d = '0;
          done_d  = 1'b0;
          state_d = start ? RUN : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
        done_d  = 1'b0;
      end
    endcase
  end

  assign count   = count_q;
  assign limit   = limit_q;
  assign busy    = (state_q == RUN);
  assign match_n = match_n_w;
  assign done    = done_q;

endmodule

// File: doc/match_seq.md
MATCH_SEQ -- requirements
Module: match_seq

Interface
REQ-001 Parameter: WIDTH, default 6, width of the limit register and the event counter.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: ld  input  1  load strobe for the limit register.
REQ-005 Port: limit_in  input  WIDTH  limit value captured on ld.
REQ-006 Port: start  input  1  begin a counting run.
REQ-007 Port: inc  input  1  event strobe; one count per asserted cycle.
REQ-008 Port: auto  input  1  1 = auto-reload (free-running divider); 0 = one-shot; sampled every cycle.
REQ-009 Port: ack  input  1  acknowledge of one-shot completion.
REQ-010 Port: count  output  WIDTH  current event count, registered.
REQ-011 Port: limit  output  WIDTH  current limit register, registered.
REQ-012 Port: busy  output  1  high in RUN state.
REQ-013 Port: match_n  output  1  active-low combinational equality flag, low when count == limit.
REQ-014 Port: done  output  1  registered completion flag.

Function
REQ-015 The block SHALL implement three states: IDLE, RUN and HOLD.
REQ-016 IDLE: count held at 0; busy=0; done=0.
REQ-017 In IDLE or HOLD, ld=1 SHALL load limit_in into limit on the next edge.
REQ-018 In RUN, ld SHALL be ignored.
REQ-019 In IDLE, start=1 SHALL enter RUN with count=0.
REQ-020 inc in the start cycle SHALL be ignored.
REQ-021 In IDLE, simultaneous ld and start SHALL both take effect; the run uses the new limit.
REQ-022 In RUN, inc=1 with count != limit SHALL increment count by 1.
REQ-023 In RUN, inc=1 with count == limit is the terminal event.
REQ-024 Terminal event with auto=0: count holds at limit, state moves to HOLD, done=1 from the next cycle.
REQ-025 Terminal event with auto=1: count returns to 0, state stays RUN, done pulses high for exactly one cycle.
REQ-026 Period SHALL be limit+1 inc events.
REQ-027 limit=0: every inc in RUN is a terminal event.
REQ-028 limit=2^WIDTH-1: count reaches all-ones before the terminal event and never wraps past limit.
REQ-029 HOLD: done stays 1 and busy=0 until ack=1.
REQ-030 ack in HOLD SHALL clear done, set count=0 and enter IDLE.
REQ-031 ack and start together in HOLD SHALL enter RUN with count=0 and done=0.
REQ-032 start in RUN SHALL be ignored.
REQ-033 inc outside RUN SHALL be ignored.
REQ-034 ack outside HOLD SHALL be ignored.
REQ-035 match_n SHALL be the NAND over all bits of bitwise XNOR(count, limit) and SHALL be valid in every state.
REQ-036 Latency: count and done update one cycle after the qualifying input.
REQ-037 match_n follows count/limit with no added register.

Reset
REQ-038 reset=1 at a clock edge SHALL force IDLE, count=0, limit=0, done=0 and busy=0, overriding all other inputs in that cycle.
REQ-039 reset mid-RUN or in HOLD SHALL abandon the run with no done pulse.
REQ-040 After reset, match_n SHALL be 0, since count == limit == 0.

Structure
REQ-041 State encoding (IDLE/RUN/HOLD) and the default WIDTH SHALL live in the shared package used by the comparator and counter blocks.
REQ-042 One sub-module SHALL be used: eq_cmp, a WIDTH-bit active-low equality comparator producing match_n.
REQ-043 The FSM, counter and limit register SHALL be in the top module.

Verification
REQ-044 Load limit=5, auto=0, start, 6 inc pulses -> count 0..5, done=1 the cycle after the 6th inc, busy=0; ack -> IDLE, count=0.
REQ-045 limit=3, auto=1, start, 12 continuous inc -> done pulses exactly 3 times, each one cycle wide, 4 cycles apart; count sequence 0,1,2,3,0,...
REQ-046 limit=0, auto=1, inc held high -> done high every cycle after the first inc, count stays 0, match_n stays 0.
REQ-047 limit=63, auto=0 -> done after the 64th inc; count=63 in HOLD; ld with limit_in=10 in HOLD -> limit=10, match_n=1.
REQ-048 RUN with count=4: ld and start asserted -> limit and count unchanged; reset asserted -> next cycle IDLE, count=0, limit=0, done=0.
REQ-049 HOLD with ack+start in the same cycle -> next cycle RUN, count=0, done=0, busy=1.
